// File: rtl/usb_pkt_pkg.sv
// Shared definitions for the USB packet engine: opcodes, default magic
// values, FSM state encoding, header field positions and small helpers.
package usb_pkt_pkg;

    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_INCR = 8'h02;
    localparam logic [7:0] OP_INV  = 8'h03;

    localparam logic [7:0] DEF_MAGIC_IN  = 8'hA5;
    localparam logic [7:0] DEF_MAGIC_OUT = 8'h5A;

    // Header field slice positions
    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 24;
    localparam int OPC_HI   = 23;
    localparam int OPC_LO   = 16;
    localparam int LEN_HI   = 15;
    localparam int LEN_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_DISCARD
    } state_t;

    // True for opcodes the transform block understands
    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_INCR) || (op == OP_INV);
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/usb_pkt_engine_xform.sv
// Combinational per-word payload transform selected by opcode.
module pkt_xform
    import usb_pkt_pkg::*;
(
    input  logic [7:0]  opcode,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0] incr_word;

    // Each byte increments independently; no carry crosses byte lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign incr_word[gi*8 +: 8] = word[gi*8 +: 8] + 8'd1;
        end
    endgenerate

    // Select the transform for the latched opcode
    always_comb begin
        result = word;
        case (opcode)
            OP_INCR: result = incr_word;
            OP_INV:  result = ~word;
            default: result = word;
        endcase
    end

endmodule

// File: rtl/usb_pkt_engine.sv
// Command packet parser/responder between the FT601 receive and transmit
// paths. Emits header, transformed payload and XOR trailer per request.
module usb_pkt_engine
    import usb_pkt_pkg::*;
#(
    parameter logic [7:0] MAGIC_IN  = DEF_MAGIC_IN,
    parameter logic [7:0] MAGIC_OUT = DEF_MAGIC_OUT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    state_t      state_reg;
    logic [7:0]  opcode_reg;
    logic [15:0] remain_reg;
    logic [31:0] csum_reg;
    logic [31:0] out_data_reg;
    logic        out_valid_reg;
    logic [15:0] pkt_cnt_reg;
    logic [15:0] err_cnt_reg;

    logic        out_free;
    logic        ready_by_state;
    logic [31:0] xf_word;

    wire [7:0]  hdr_magic = in_data[MAGIC_HI:MAGIC_LO];
    wire [7:0]  hdr_op    = in_data[OPC_HI:OPC_LO];
    wire [15:0] hdr_len   = in_data[LEN_HI:LEN_LO];

    pkt_xform u_xform (
        .opcode (opcode_reg),
        .word   (in_data),
        .result (xf_word)
    );

    // Output register can take a new word when empty or being drained now
    assign out_free = ~out_valid_reg | out_ready;

    // Input acceptance per state; held low while in reset
    always_comb begin
        ready_by_state = 1'b0;
        case (state_reg)
            ST_IDLE:    ready_by_state = 1'b1;
            ST_DISCARD: ready_by_state = 1'b1;
            ST_PAYLOAD: ready_by_state = out_free;
            default:    ready_by_state = 1'b0;
        endcase
    end

    assign in_ready  = reset & ready_by_state;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign pkt_cnt   = pkt_cnt_reg;
    assign err_cnt   = err_cnt_reg;
    assign busy      = (state_reg != ST_IDLE);

    // Main FSM with remaining-word counter, checksum and output register
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            opcode_reg    <= 8'h00;
            remain_reg    <= 16'h0000;
            csum_reg      <= 32'h0;
            out_data_reg  <= 32'h0;
            out_valid_reg <= 1'b0;
            pkt_cnt_reg   <= 16'h0000;
            err_cnt_reg   <= 16'h0000;
        end else begin
            // Drop valid after a handshake unless something is reloaded below
            if (out_valid_reg && out_ready)
                out_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (hdr_magic != MAGIC_IN) begin
                            err_cnt_reg <= sat_inc16(err_cnt_reg);
                        end else if (!op_known(hdr_op)) begin
                            err_cnt_reg <= sat_inc16(err_cnt_reg);
                            remain_reg  <= hdr_len;
                            if (hdr_len != 16'h0000)
                                state_reg <= ST_DISCARD;
                        end else begin
                            opcode_reg <= hdr_op;
                            remain_reg <= hdr_len;
                            state_reg  <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (out_free) begin
                        out_data_reg  <= {MAGIC_OUT, opcode_reg, remain_reg};
                        out_valid_reg <= 1'b1;
                        csum_reg      <= 32'h0;
                        state_reg     <= (remain_reg != 16'h0000) ? ST_PAYLOAD : ST_TRAILER;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid && out_free) begin
                        out_data_reg  <= xf_word;
                        out_valid_reg <= 1'b1;
                        csum_reg      <= csum_reg ^ xf_word;
                        remain_reg    <= remain_reg - 16'd1;
                        if (remain_reg == 16'd1)
                            state_reg <= ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (out_free) begin
                        out_data_reg  <= csum_reg;
                        out_valid_reg <= 1'b1;
                        pkt_cnt_reg   <= sat_inc16(pkt_cnt_reg);
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (in_valid) begin
                        remain_reg <= remain_reg - 16'd1;
                        if (remain_reg == 16'd1)
                            state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_pkt_engine.sv
// Self-checking bench for usb_pkt_engine: packet-level reference model,
// randomized valid/ready, per-cycle output compare.
module tb_usb_pkt_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic        busy;

    usb_pkt_engine dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] in_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] exp_q[$];
    int          exp_pkt = 0;
    int          exp_err = 0;
    bit          chk_en = 1'b0;
    int          valid_pct = 100;
    int          ready_pct = 100;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference transform from the opcode definitions
    function automatic logic [31:0] xf_model(input logic [7:0] op, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (op == 8'h02) begin
            for (int b = 0; b < 4; b++) r[b*8 +: 8] = 8'((w[b*8 +: 8] + 1) % 256);
        end else if (op == 8'h03) begin
            r = 32'hFFFFFFFF ^ w;
        end
        return r;
    endfunction

    task automatic add_word(input logic [31:0] w);
        in_q.push_back(w);
        pend_q.push_back(w);
    endtask

    // Parse the pending request stream into the expected response stream
    task automatic model_flush();
        int i = 0;
        while (i < pend_q.size()) begin
            logic [31:0] h = pend_q[i];
            logic [7:0]  op = h[23:16];
            int          len = int'(h[15:0]);
            i++;
            if (h[31:24] != 8'hA5) begin
                exp_err++;
            end else if (op < 8'h01 || op > 8'h03) begin
                exp_err++;
                i += len;
            end else begin
                logic [31:0] cs = 32'h0;
                exp_q.push_back({8'h5A, op, h[15:0]});
                for (int k = 0; k < len; k++) begin
                    logic [31:0] t = xf_model(op, pend_q[i]);
                    i++;
                    exp_q.push_back(t);
                    cs ^= t;
                end
                exp_q.push_back(cs);
                exp_pkt++;
            end
        end
        pend_q.delete();
    endtask

    // Drive queued request words until everything expected has come out
    task automatic run(input int max_cyc);
        int cyc = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || busy) && cyc < max_cyc) begin
            @(posedge clk);
            in_valid  = (in_q.size() > 0) && ($urandom_range(99) < valid_pct);
            in_data   = in_valid ? in_q[0] : $urandom;
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (in_valid && in_ready) void'(in_q.pop_front());
            cyc++;
        end
        if (cyc >= max_cyc) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d inputs and %0d outputs left after %0d cycles", in_q.size(), exp_q.size(), cyc);
            in_q.delete();
            exp_q.delete();
        end
        @(posedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check32("idle_out_valid", {31'h0, out_valid}, 32'h0);
        check32("idle_busy", {31'h0, busy}, 32'h0);
        check32("pkt_cnt", {16'h0, pkt_cnt}, exp_pkt);
        check32("err_cnt", {16'h0, err_cnt}, exp_err);
    endtask

    // Per-cycle compare of the response stream and stall stability
    always @(posedge clk) begin
        #1;
        if (chk_en && reset) begin
            if (prev_stall) begin
                check32("stall_valid", {31'h0, out_valid}, 32'h1);
                check32("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no word", out_data);
                end else begin
                    check32("out_word", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        // Reset values
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check32("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check32("rst_out_data", out_data, 32'h0);
        check32("rst_pkt_cnt", {16'h0, pkt_cnt}, 32'h0);
        check32("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
        check32("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
        #1;
        check32("idle_in_ready", {31'h0, in_ready}, 32'h1);
        chk_en = 1'b1;

        // ECHO length 2, full rate
        add_word(32'hA5010002); add_word(32'h01020304); add_word(32'hFFFFFFFF);
        model_flush();
        check32("model_echo_h", exp_q[0], 32'h5A010002);
        check32("model_echo_t", exp_q[3], 32'hFEFDFCFB);
        run(200);
        check32("echo_pkt_cnt", {16'h0, pkt_cnt}, 32'd1);

        // INCR length 1
        add_word(32'hA5020001); add_word(32'h00FF7F10);
        model_flush();
        check32("model_incr_w", exp_q[1], 32'h01008011);
        check32("model_incr_t", exp_q[2], 32'h01008011);
        run(200);

        // Bad magic then INV length 0
        add_word(32'h11010003); add_word(32'hA5030000);
        model_flush();
        check32("model_badmagic_n", exp_q.size(), 32'd2);
        check32("model_badmagic_e", exp_err, 32'd1);
        run(200);

        // Unknown opcode with 2 discarded words, then ECHO length 0
        add_word(32'hA5770002); add_word(32'h12345678); add_word(32'hA5010003);
        add_word(32'hA5010000);
        model_flush();
        check32("model_unk_h", exp_q[0], 32'h5A010000);
        check32("model_unk_e", exp_err, 32'd2);
        run(200);

        // ECHO length 4 with random output stalls
        ready_pct = 50;
        add_word(32'hA5010004);
        for (int k = 0; k < 4; k++) add_word($urandom);
        model_flush();
        run(400);

        // Random mix of good, bad-magic and unknown-opcode packets
        valid_pct = 70;
        ready_pct = 60;
        for (int p = 0; p < 25; p++) begin
            int          sel = $urandom_range(9);
            int          len = $urandom_range(6);
            logic [7:0]  mg = 8'hA5;
            logic [7:0]  op = 8'($urandom_range(1, 3));
            if (sel == 0) begin
                mg = 8'($urandom);
                if (mg == 8'hA5) mg = 8'h00;
                len = 0;
            end else if (sel == 1) begin
                op = (p % 2 == 0) ? 8'h77 : 8'h00;
            end
            add_word({mg, op, 16'(len)});
            for (int k = 0; k < len; k++) add_word($urandom);
        end
        model_flush();
        run(5000);

        // Reset in the middle of a payload
        valid_pct = 100;
        ready_pct = 100;
        chk_en = 1'b0;
        @(posedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hA5010004;
        @(posedge clk); in_data = 32'hCAFEF00D;
        @(posedge clk); in_data = 32'h0BADBEEF;
        @(posedge clk); in_valid = 1'b0;
        #1;
        check32("mid_busy", {31'h0, busy}, 32'h1);
        @(posedge clk);
        reset = 1'b0;
        #1;
        check32("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check32("midrst_busy", {31'h0, busy}, 32'h0);
        check32("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
        exp_pkt = 0;
        exp_err = 0;
        exp_q.delete();
        chk_en = 1'b1;
        add_word(32'hA5030001); add_word(32'h0F0F0000);
        model_flush();
        run(200);
        check32("post_rst_pkt_cnt", {16'h0, pkt_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_pkt_engine.md
# usb_pkt_engine

Packet-processing stage between the FT601 parallel-FIFO bus interface's receive path and its transmit path. It parses 32-bit command packets arriving from the PC and applies the requested per-word transform to the payload. It then emits a response packet (header, transformed payload, XOR checksum trailer) toward the transmit path, and keeps packet and error counters for debug readout on GPIO/status logic.

## Interface
- `MAGIC_IN`, default 8'hA5: required value of request header bits [31:24].
- `MAGIC_OUT`, default 8'h5A: value placed in response header bits [31:24].
- `clk` in 1: FT601 bus clock. All state updates on the falling edge, same as the bus interface.
- `reset` in 1: asynchronous, active-low reset.
- `in_data` in 32: request word from the receive path.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: engine accepts `in_data`. Transfer occurs when `in_valid & in_ready` at the clock edge.
- `out_data` out 32: response word toward the transmit path (registered).
- `out_valid` out 1: `out_data` valid (registered).
- `out_ready` in 1: transmit path accepts `out_data`.
- `pkt_cnt` out 16: completed response packets, saturating at 16'hFFFF.
- `err_cnt` out 16: rejected headers (bad magic or unknown opcode), saturating at 16'hFFFF.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- Request header format: [31:24] magic, [23:16] opcode, [15:0] payload length in words (0–65535).
- Opcodes:
  - 8'h01 ECHO: word passed through unchanged.
  - 8'h02 INCR: each byte +1 mod 256, with no carry between bytes.
  - 8'h03 INV: bitwise NOT.
- Response: header {MAGIC_OUT, opcode, length}, then `length` transformed words, then a trailer equal to the XOR of all transformed payload words. The trailer is 32'h0 when length = 0.
- States:
  - IDLE: `in_ready`=1. A word accepted here is treated as a header.
    - Bad magic: word dropped, `err_cnt`+1, stay in IDLE.
    - Good magic, unknown opcode: `err_cnt`+1, → DISCARD, or stay in IDLE if length = 0.
    - Good magic, known opcode: latch opcode and length, → HDR.
  - HDR: `in_ready`=0. When the output register is free (`~out_valid | out_ready`), load the response header and clear the checksum. Next state is PAYLOAD if length > 0, otherwise TRAILER.
  - PAYLOAD: `in_ready = ~out_valid | out_ready`. Each accepted word is transformed and loaded into the output register on the same edge. The checksum is XORed with the transformed word and the remaining count is decremented. After the last word is accepted, → TRAILER.
  - TRAILER: `in_ready`=0. When the output register is free, load the checksum, `pkt_cnt`+1, → IDLE.
  - DISCARD: `in_ready`=1. Consume `length` words with no output, then → IDLE.
- The output register holds `out_data` stable while `out_valid & ~out_ready`. `out_valid` drops after the final handshake if nothing new is loaded on that edge.
- Reset values: `in_ready`=0 while `reset` is low, then 1 (IDLE). `out_valid`=0, `out_data`=0, `pkt_cnt`=0, `err_cnt`=0, `busy`=0, state IDLE, checksum and count 0.
- Reset mid-packet aborts the packet immediately. The remaining upstream words of that packet are then parsed as headers and will normally count as errors.

## Timing
- Header accepted at edge N: response header `out_valid` at edge N+1 if the output register is free.
- Payload throughput is one word per clock when `in_valid` and `out_ready` are held high. The latency from input to output is one edge.
- Trailer is loaded on the first free edge after the last payload word is loaded, so a full-rate packet takes length + 2 output cycles.
- Backpressure: `out_ready`=0 stalls `in_ready` in PAYLOAD on the same cycle, so no word is lost or duplicated.
- If the counter increment and saturation coincide, the counter holds at 16'hFFFF.

## Structure
- Shared package `usb_pkt_pkg`: opcode constants, default magic values, state enum, and the header field slice positions.
- One combinational sub-module, `pkt_xform`: inputs opcode and word, output the transformed word. The package is reused by future opcodes.
- Everything else is a single FSM with a remaining-word counter, checksum register and output register.

## Test plan
- ECHO, length 2, words 32'h01020304 and 32'hFFFFFFFF, `out_ready`=1 → outputs 32'h5A010002, 32'h01020304, 32'hFFFFFFFF, 32'hFEFDFCFB. `pkt_cnt`=1.
- INCR, length 1, word 32'h00FF7F10 → outputs 32'h5A020001, 32'h01008011, 32'h01008011.
- Bad magic 32'h11010003, then valid INV length 0 → `err_cnt`=1, and the outputs are only 32'h5A030000, 32'h00000000.
- Unknown opcode 32'hA5770002 followed by 2 words, then ECHO length 0 → the 2 words are discarded silently, `err_cnt`=1, and the outputs are 32'h5A010000, 32'h00000000.
- ECHO, length 4, with random `out_ready` stalls → the output sequence is identical to the no-stall run, and `out_data` is stable while stalled.
- Reset asserted during PAYLOAD → `out_valid`=0 and state IDLE immediately. A following valid packet completes normally with `pkt_cnt`=1.
